cccp_lut_arbiter: RTL
=====================

CCCP_LUT_ARBITER -- requirements
Module: cccp_lut_arbiter

Interface
REQ-001 Parameter LPM_LUT_DEPTH_BITS, default 4: CCCP LUT address width.
REQ-002 Parameter NAME_LENTH, default 32: content-name width.
REQ-003 Parameter VN_LENTH, default 16: version-number width.
REQ-004 Parameter NUM_QUEUES, default 5: output-queue bitmap width.
REQ-005 Parameter TIMEOUT, default 64: maximum cycles waited for a LUT ack (range 2..65535).
REQ-006 Local width W = NAME_LENTH+VN_LENTH+NUM_QUEUES+32, packed as {name, vn, oq, next_hop_ip}, with name in the MSBs.
REQ-007 clk  in  1  sole clock; all logic is rising-edge.
REQ-008 reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-009 a_req, b_req  in  1  level request; requester A is the register path, requester B is the hardware learn path.
REQ-010 a_wr, b_wr  in  1  1 = write, 0 = read; stable while req is high.
REQ-011 a_addr, b_addr  in  LPM_LUT_DEPTH_BITS  entry index.
REQ-012 a_wdata, b_wdata  in  W  write entry.
REQ-013 a_ack, b_ack  out  1  one-cycle completion pulse.
REQ-014 a_err, b_err  out  1  timeout flag; valid only with ack.
REQ-015 rdata  out  W  last read result.
REQ-016 cccp_rd_addr / cccp_rd_req  out  LPM_LUT_DEPTH_BITS / 1  LUT read port.
REQ-017 cccp_rd_name, cccp_rd_vn, cccp_rd_oq, cccp_rd_next_hop_ip  in  NAME_LENTH, VN_LENTH, NUM_QUEUES, 32  LUT read data.
REQ-018 cccp_rd_ack  in  1  read-done pulse.
REQ-019 cccp_wr_addr / cccp_wr_req  out  LPM_LUT_DEPTH_BITS / 1  LUT write port.
REQ-020 cccp_wr_name, cccp_wr_vn, cccp_wr_oq, cccp_wr_next_hop_ip  out  same widths  LUT write data.
REQ-021 cccp_wr_ack  in  1  write-done pulse.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-023 IDLE: if exactly one req is high, the arbiter SHALL grant that requester; if both are high, it SHALL grant the requester not served last (last_grant). The arbiter SHALL latch the granted wr, addr and wdata, update last_grant, and go to ISSUE.
REQ-024 ISSUE: the arbiter SHALL pulse cccp_rd_req or cccp_wr_req for exactly one cycle, with addr/data driven from the latched registers and held stable until DONE. It SHALL clear the timeout counter, then go to WAIT, or go directly to DONE if the matching ack is high in this cycle.
REQ-025 WAIT: the matching ack SHALL cause a transition to DONE; the non-matching ack SHALL be ignored. The counter SHALL increment each cycle; when the counter reaches TIMEOUT-1 without an ack, the arbiter SHALL go to DONE with err set.
REQ-026 On cccp_rd_ack during a read, the arbiter SHALL capture {rd_name, rd_vn, rd_oq, rd_next_hop_ip} into rdata. rdata SHALL hold until the next successful read; timed-out reads SHALL leave rdata unchanged.
REQ-027 DONE: the arbiter SHALL assert the granted x_ack for one cycle, with x_err, then return to IDLE. The requester drops req on the same edge, so IDLE never re-grants a completed request.
REQ-028 Latency: req seen in IDLE at cycle 0 with LUT ack in ISSUE -> ack at cycle 2. With LUT ack k cycles after ISSUE -> ack at cycle 2+k.
REQ-029 Acks arriving in IDLE or DONE SHALL be ignored.
REQ-030 A req dropped before grant is discarded. A req dropped after grant still completes, and the ack still pulses.
REQ-031 Only one LUT operation SHALL be outstanding at any time. Rd_req and wr_req SHALL never be high together.

Reset
REQ-032 Reset low SHALL asynchronously force IDLE, last_grant=B, counter=0, and all outputs to 0, including rdata. Reset mid-operation SHALL abandon the operation with no ack. After reset release, the first operation SHALL start from IDLE.

Verification
REQ-033 A read addr 3, LUT returns name=0xCAFE0001, vn=0x0007, oq=0x04, nh=0x0A000001 one cycle after rd_req -> a_ack at cycle 3, a_err=0, rdata = those values.
REQ-034 a_req and b_req both high from reset -> A granted first, B next. Repeat with both held -> grants alternate A, B, A, B.
REQ-035 B write addr 15, LUT never acks (TIMEOUT=64) -> b_ack with b_err=1 exactly 64 cycles after the ISSUE cycle, and rdata unchanged.
REQ-036 cccp_rd_ack pulsed during a write in WAIT -> ignored; a later wr_ack completes it. A stray ack in IDLE -> no ack outputs.
REQ-037 Reset pulled low during WAIT -> outputs 0 immediately and no ack. A new A read after release completes normally.

Source files
------------

// File: rtl/cccp_lut_arbiter.sv
// Two-requester arbiter for the CCCP LUT: register path (A) and learn path (B).
// Only one LUT read or write is in flight; every granted request ends in an ack pulse, with err set on timeout.
module cccp_lut_arbiter #(
    parameter int LPM_LUT_DEPTH_BITS = 4,
    parameter int NAME_LENTH         = 32,
    parameter int VN_LENTH           = 16,
    parameter int NUM_QUEUES         = 5,
    parameter int TIMEOUT            = 64
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          a_req,
    input  logic                                          a_wr,
    input  logic [LPM_LUT_DEPTH_BITS-1:0]                 a_addr,
    input  logic [NAME_LENTH+VN_LENTH+NUM_QUEUES+32-1:0]  a_wdata,
    output logic                                          a_ack,
    output logic                                          a_err,
    input  logic                                          b_req,
    input  logic                                          b_wr,
    input  logic [LPM_LUT_DEPTH_BITS-1:0]                 b_addr,
    input  logic [NAME_LENTH+VN_LENTH+NUM_QUEUES+32-1:0]  b_wdata,
    output logic                                          b_ack,
    output logic                                          b_err,
    output logic [NAME_LENTH+VN_LENTH+NUM_QUEUES+32-1:0]  rdata,
    output logic [LPM_LUT_DEPTH_BITS-1:0]                 cccp_rd_addr,
    output logic                                          cccp_rd_req,
    input  logic [NAME_LENTH-1:0]                         cccp_rd_name,
    input  logic [VN_LENTH-1:0]                           cccp_rd_vn,
    input  logic [NUM_QUEUES-1:0]                         cccp_rd_oq,
    input  logic [31:0]                                   cccp_rd_next_hop_ip,
    input  logic                                          cccp_rd_ack,
    output logic [LPM_LUT_DEPTH_BITS-1:0]                 cccp_wr_addr,
    output logic                                          cccp_wr_req,
    output logic [NAME_LENTH-1:0]                         cccp_wr_name,
    output logic [VN_LENTH-1:0]                           cccp_wr_vn,
    output logic [NUM_QUEUES-1:0]                         cccp_wr_oq,
    output logic [31:0]                                   cccp_wr_next_hop_ip,
    input  logic                                          cccp_wr_ack,
    output logic [1:0]                                    o_state
);
    localparam int W = NAME_LENTH + VN_LENTH + NUM_QUEUES + 32;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

    state_t                          r_state;
    logic                            r_gnt_b;
    logic                            r_last_b;
    logic                            r_wr;
    logic [LPM_LUT_DEPTH_BITS-1:0]   r_addr;
    logic [W-1:0]                    r_wdata;
    logic [W-1:0]                    r_rdata;
    logic [15:0]                     r_cnt;
    logic                            r_rd_req;
    logic                            r_wr_req;
    logic                            r_a_ack;
    logic                            r_b_ack;
    logic                            r_a_err;
    logic                            r_b_err;

    logic                            w_grant_b;
    logic                            w_gnt_wr;
    logic                            w_match_ack;
    logic [15:0]                     w_cnt_inc;
    logic [W-1:0]                    w_rd_word;

    // With both requesting, B wins only if A was served last.
    assign w_grant_b   = b_req & (~a_req | ~r_last_b);
    assign w_gnt_wr    = w_grant_b ? b_wr : a_wr;
    assign w_match_ack = r_wr ? cccp_wr_ack : cccp_rd_ack;
    assign w_cnt_inc   = r_cnt + 16'd1;
    assign w_rd_word   = {cccp_rd_name, cccp_rd_vn, cccp_rd_oq, cccp_rd_next_hop_ip};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_gnt_b  <= 1'b0;
            r_last_b <= 1'b1;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
        end else begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (a_req | b_req) begin
                        r_gnt_b  <= w_grant_b;
                        r_last_b <= w_grant_b;
                        r_wr     <= w_gnt_wr;
                        r_addr   <= w_grant_b ? b_addr : a_addr;
                        r_wdata  <= w_grant_b ? b_wdata : a_wdata;
                        r_rd_req <= ~w_gnt_wr;
                        r_wr_req <= w_gnt_wr;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                    if (w_match_ack) begin
                        if (!r_wr) r_rdata <= w_rd_word;
                        r_a_ack <= ~r_gnt_b;
                        r_b_ack <= r_gnt_b;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_match_ack) begin
                        if (!r_wr) r_rdata <= w_rd_word;
                        r_a_ack <= ~r_gnt_b;
                        r_b_ack <= r_gnt_b;
                        r_state <= S_DONE;
                    end else if (w_cnt_inc == TO_LAST) begin
                        // Timed out: ack with err, rdata left as it was.
                        r_a_ack <= ~r_gnt_b;
                        r_b_ack <= r_gnt_b;
                        r_a_err <= ~r_gnt_b;
                        r_b_err <= r_gnt_b;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a_ack               = r_a_ack;
    assign b_ack               = r_b_ack;
    assign a_err               = r_a_err;
    assign b_err               = r_b_err;
    assign rdata               = r_rdata;
    assign cccp_rd_req         = r_rd_req;
    assign cccp_wr_req         = r_wr_req;
    assign cccp_rd_addr        = r_addr;
    assign cccp_wr_addr        = r_addr;
    assign {cccp_wr_name, cccp_wr_vn, cccp_wr_oq, cccp_wr_next_hop_ip} = r_wdata;
    assign o_state             = r_state;
endmodule
